regfile_write_scheduler: RTL
============================

# regfile_write_scheduler

Shares the two write ports of the register block between up to NREQ write-back sources (ALU, load unit, HI/LO move, etc.). Each cycle it grants at most two pending requests in round-robin order, never two to the same register, and drives them onto the register block's port 1 (`write_reg1`/`write_data1`/`reg_write`) and port 2 (`write_reg2`/`write_data2`/`enable`) from registered outputs. Writes to `$zero` are consumed without using a port.

## Interface
- `NREQ`, 4: number of requesters, from 2 to 8.
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hold` in 1: when 1, no grants are issued and both ports are idle on the next cycle.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_addr` in NREQ*AW: destination register. Requester i uses bits [i*AW +: AW].
- `req_data` in NREQ*DW: write data. Requester i uses bits [i*DW +: DW].
- `req_ready` out NREQ: combinational grant. A transfer occurs when valid && ready at the clock edge.
- `write_reg1` out AW, `write_data1` out DW, `reg_write` out 1: port 1 of the register block.
- `write_reg2` out AW, `write_data2` out DW, `enable` out 1: port 2 of the register block.
- `write_count` out 16: number of port writes issued. Wraps modulo 2^16.

## Operation
- Requester rules:
  - `req_valid` must not depend on `req_ready`.
  - Address and data stay stable while valid and not ready.
- `rr_ptr` (log2 NREQ bits) is the highest-priority index. Scan order is rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
- Zero-register requests (valid and addr==0):
  - Granted in the same cycle regardless of port availability. This includes while `hold`=1.
  - They never drive a port and never move rr_ptr.
- Port grants (nonzero addresses, `hold`=0):
  - The first valid requester in scan order gets slot A.
  - The next valid requester whose addr differs from A's addr gets slot B.
  - A skipped same-address requester stays pending and keeps its position.
- Port mapping on the next edge:
  - Slot A goes to port 1: `reg_write`=1, `write_reg1`/`write_data1` = A's addr/data.
  - Slot B goes to port 2: `enable`=1, `write_reg2`/`write_data2` = B's addr/data.
  - An unused port has its strobe at 0. Its addr/data hold their previous values.
- rr_ptr update on a cycle with any port grant: set to (index of last port-granted requester + 1) mod NREQ. Otherwise unchanged.
- `write_count` increments by the number of port strobes asserted on that edge (0, 1 or 2).
- `hold`=1 blocks port grants. Both strobes go to 0 on the next edge. Pending requests stay pending.

## Timing
- Reset values:
  - All output registers 0: `reg_write`, `enable`, `write_reg1/2`, `write_data1/2`.
  - `write_count`=0 and `rr_ptr`=0.
  - `req_ready` is 0 while `rst`=1.
- Reset asserted mid-operation clears all output registers immediately, so an in-flight port write is dropped. Requesters re-present after reset.
- Latency:
  - A request accepted at edge N drives its port during cycle N..N+1.
  - The register block captures it at edge N+1, and it is readable after that edge.
- Throughput: 2 nonzero writes per cycle, plus any number of `$zero` writes.
- Fairness: a continuously valid requester is port-granted within ceil(NREQ/2) grant cycles, excluding same-address blocking.
- No combinational path from any input to any port output. `req_ready` is combinational from `req_valid`, `req_addr`, `hold`, `rr_ptr` and `rst`.

## Structure
- Shared package `regfile_pkg`: `AW`, `DW`, `REG_ZERO` = 5'd0, port-index constants `PORT1`/`PORT2`. The register block reuses these.
- One natural sub-module: `rr_pick2`. It is purely combinational and takes valid vector, address vector and rr_ptr. It returns a one-hot grant A, a one-hot grant B, and their found flags.
- The top level holds rr_ptr, the output registers and `write_count`.

## Test plan
- Reset: assert `rst` mid-burst with `reg_write`=1 → all port outputs read 0 within the same cycle; `write_count`=0; `req_ready`=0.
- Two requests:
  - Stimulus: req0 addr 10 data 0xFFFFFFFF and req1 addr 11 data 0x0; rr_ptr=0.
  - Response: both ready in one cycle. Next cycle `reg_write`=1 with reg 10 / 0xFFFFFFFF, and `enable`=1 with reg 11 / 0.
  - Register file holds both values one edge later. `write_count`=2.
- Conflict:
  - Stimulus: req0 and req1 both target reg 12 (data 0x64, 0x14); req2 targets reg 13.
  - Response: cycle 1 grants req0 to port 1 and req2 to port 2. Cycle 2 grants req1 to port 1.
  - Final reg 12 = 0x14.
- Fairness: all 4 requesters continuously valid with distinct nonzero addrs → grant pairs are {0,1}, {2,3}, {0,1}, …; rr_ptr goes 0→2→0.
- Zero register and hold:
  - Stimulus: req3 addr 0 plus req0 addr 15, with `hold`=1.
  - Response: req3 ready immediately, req0 not ready. Both strobes 0 next cycle.
  - Release `hold` → req0 is port-1 written a cycle later.
- Counter wrap: preload `write_count` to 0xFFFF by force, then issue 2 writes → `write_count`=0x0001.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register block and its write-port scheduler.
package regfile_pkg;

   localparam int AW = 5;
   localparam int DW = 32;

   // Address of the hard-wired zero register; writes to it are discarded.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Write-port indices of the register block.
   localparam logic PORT1 = 1'b0;
   localparam logic PORT2 = 1'b1;

   // Number of write strobes asserted on one edge (0, 1 or 2).
   function automatic logic [1:0] strobe_count(input logic s1, input logic s2);
      return {1'b0, s1} + {1'b0, s2};
   endfunction

endpackage

// File: rtl/regfile_write_scheduler_rr_pick2.sv
// Round-robin picker for two write slots.
// Slot A is the first valid requester in scan order starting at ptr_i.
// Slot B is the next valid requester whose address differs from slot A's.
module rr_pick2
   import regfile_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = regfile_pkg::AW,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]    valid_i,
   input  logic [NREQ*AW-1:0] addr_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NREQ-1:0]    grant_a_o,
   output logic [NREQ-1:0]    grant_b_o,
   output logic               found_a_o,
   output logic               found_b_o
);

   logic [AW-1:0] addr_s [NREQ];
   logic [PW:0]   sum_s;
   logic [PW-1:0] idx_s;
   logic [AW-1:0] addr_a_s;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_s[g] = addr_i[g*AW +: AW];
   end

   // Walk the requesters in rotated order and claim up to two slots.
   always_comb begin
      grant_a_o = '0;
      grant_b_o = '0;
      found_a_o = 1'b0;
      found_b_o = 1'b0;
      sum_s     = '0;
      idx_s     = '0;
      addr_a_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum_s = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum_s >= (PW+1)'(NREQ)) begin
            sum_s = sum_s - (PW+1)'(NREQ);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[PW-1:0];
         if (valid_i[idx_s] && !found_a_o) begin
            found_a_o        = 1'b1;
            grant_a_o[idx_s] = 1'b1;
            addr_a_s         = addr_s[idx_s];
         end else if (valid_i[idx_s] && !found_b_o && (addr_s[idx_s] != addr_a_s)) begin
            found_b_o        = 1'b1;
            grant_b_o[idx_s] = 1'b1;
         end else begin
            // Same-address or idle requester: it keeps its place for a later cycle.
            found_b_o = found_b_o;
         end
      end
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Schedules up to NREQ write-back sources onto the two register-block write
// ports. Zero-register writes are absorbed without occupying a port.
module regfile_write_scheduler
   import regfile_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = regfile_pkg::AW,
   parameter int DW   = regfile_pkg::DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [AW-1:0]      write_reg1,
   output logic [DW-1:0]      write_data1,
   output logic               reg_write,
   output logic [AW-1:0]      write_reg2,
   output logic [DW-1:0]      write_data2,
   output logic               enable,
   output logic [15:0]        write_count
);

   localparam int PW = $clog2(NREQ);

   logic [AW-1:0]   req_addr_s [NREQ];
   logic [DW-1:0]   req_data_s [NREQ];
   logic [NREQ-1:0] zero_hit_s;
   logic [NREQ-1:0] port_valid_s;
   logic [NREQ-1:0] grant_a_s;
   logic [NREQ-1:0] grant_b_s;
   logic            found_a_s;
   logic            found_b_s;

   logic [AW-1:0]   slot_addr_s [2];
   logic [DW-1:0]   slot_data_s [2];
   logic [PW-1:0]   slot_idx_s  [2];

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            reg_write_q, reg_write_d;
   logic            enable_q, enable_d;
   logic [AW-1:0]   write_reg1_q, write_reg1_d;
   logic [AW-1:0]   write_reg2_q, write_reg2_d;
   logic [DW-1:0]   write_data1_q, write_data1_d;
   logic [DW-1:0]   write_data2_q, write_data2_d;
   logic [15:0]     write_count_q, write_count_d;

   // Requester index following idx, wrapping at NREQ.
   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
      if (idx == PW'(NREQ-1)) begin
         return '0;
      end else begin
         return idx + PW'(1'b1);
      end
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_addr_s[g] = req_addr[g*AW +: AW];
      assign req_data_s[g] = req_data[g*DW +: DW];
   end

   // Split pending requests into zero-register writes and port candidates.
   always_comb begin
      zero_hit_s   = '0;
      port_valid_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_addr_s[i] == AW'(REG_ZERO)) begin
            zero_hit_s[i]   = req_valid[i];
            port_valid_s[i] = 1'b0;
         end else begin
            zero_hit_s[i]   = 1'b0;
            port_valid_s[i] = req_valid[i] & ~hold;
         end
      end
   end

   rr_pick2 #(
      .NREQ (NREQ),
      .AW   (AW),
      .PW   (PW)
   ) u_pick (
      .valid_i   (port_valid_s),
      .addr_i    (req_addr),
      .ptr_i     (rr_ptr_q),
      .grant_a_o (grant_a_s),
      .grant_b_o (grant_b_s),
      .found_a_o (found_a_s),
      .found_b_o (found_b_s)
   );

   // Grant handshake; nothing is accepted while reset is asserted.
   always_comb begin
      if (rst) begin
         req_ready = '0;
      end else begin
         req_ready = zero_hit_s | grant_a_s | grant_b_s;
      end
   end

   // One-hot AND-OR mux of the granted requesters into the two slots.
   always_comb begin
      slot_addr_s[PORT1] = '0;
      slot_addr_s[PORT2] = '0;
      slot_data_s[PORT1] = '0;
      slot_data_s[PORT2] = '0;
      slot_idx_s[PORT1]  = '0;
      slot_idx_s[PORT2]  = '0;
      for (int i = 0; i < NREQ; i++) begin
         slot_addr_s[PORT1] = slot_addr_s[PORT1] | (req_addr_s[i] & {AW{grant_a_s[i]}});
         slot_data_s[PORT1] = slot_data_s[PORT1] | (req_data_s[i] & {DW{grant_a_s[i]}});
         slot_idx_s[PORT1]  = slot_idx_s[PORT1]  | (PW'(i) & {PW{grant_a_s[i]}});
         slot_addr_s[PORT2] = slot_addr_s[PORT2] | (req_addr_s[i] & {AW{grant_b_s[i]}});
         slot_data_s[PORT2] = slot_data_s[PORT2] | (req_data_s[i] & {DW{grant_b_s[i]}});
         slot_idx_s[PORT2]  = slot_idx_s[PORT2]  | (PW'(i) & {PW{grant_b_s[i]}});
      end
   end

   // Next-state for pointer, port registers and write counter.
   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      reg_write_d   = found_a_s;
      enable_d      = found_b_s;
      write_reg1_d  = write_reg1_q;
      write_data1_d = write_data1_q;
      write_reg2_d  = write_reg2_q;
      write_data2_d = write_data2_q;
      write_count_d = write_count_q + {14'd0, strobe_count(found_a_s, found_b_s)};

      // Priority moves just past the last requester that got a port.
      if (found_b_s) begin
         rr_ptr_d = ptr_after(slot_idx_s[PORT2]);
      end else if (found_a_s) begin
         rr_ptr_d = ptr_after(slot_idx_s[PORT1]);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end

      // An unused port keeps its last address/data; only the strobe drops.
      if (found_a_s) begin
         write_reg1_d  = slot_addr_s[PORT1];
         write_data1_d = slot_data_s[PORT1];
      end else begin
         write_reg1_d  = write_reg1_q;
         write_data1_d = write_data1_q;
      end

      if (found_b_s) begin
         write_reg2_d  = slot_addr_s[PORT2];
         write_data2_d = slot_data_s[PORT2];
      end else begin
         write_reg2_d  = write_reg2_q;
         write_data2_d = write_data2_q;
      end
   end

   // State registers; reset drops any in-flight port write at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         reg_write_q   <= 1'b0;
         enable_q      <= 1'b0;
         write_reg1_q  <= '0;
         write_data1_q <= '0;
         write_reg2_q  <= '0;
         write_data2_q <= '0;
         write_count_q <= 16'd0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         reg_write_q   <= reg_write_d;
         enable_q      <= enable_d;
         write_reg1_q  <= write_reg1_d;
         write_data1_q <= write_data1_d;
         write_reg2_q  <= write_reg2_d;
         write_data2_q <= write_data2_d;
         write_count_q <= write_count_d;
      end
   end

   assign reg_write   = reg_write_q;
   assign enable      = enable_q;
   assign write_reg1  = write_reg1_q;
   assign write_data1 = write_data1_q;
   assign write_reg2  = write_reg2_q;
   assign write_data2 = write_data2_q;
   assign write_count = write_count_q;

endmodule
